// File: rtl/key_event_pkg.sv
// Shared constants, the debounce state encoding and the width helper used by
// the pushbutton event capture block.
package key_event_pkg;

    localparam int N_KEYS_DEF          = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } key_state_e;

    // Bits needed to index 'value' items, never less than one.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        while ((32'd1 << w) < 32'(value)) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    localparam int KEY_W_DEF = clog2_min1(N_KEYS_DEF);

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, consecutive-cycle debounce counter,
// debounced level and a single-cycle press pulse on the released->pressed edge.
module key_debounce
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    key_state_e       stable_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pressed_s;
    logic             expire_s;

    // Two-flop synchroniser; idles at "not pressed" out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= key_n;
            sync2_r <= sync1_r;
        end
    end

    // Changed level has persisted for the full window at this edge.
    always_comb begin
        pressed_s = ~sync2_r;
        expire_s  = (pressed_s != stable_r) && (cnt_r == CNT_LAST);
    end

    // Debounce FSM: any cycle that matches the stable level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_r <= RELEASED;
            cnt_r    <= {CNT_W{1'b0}};
        end else if (pressed_s == stable_r) begin
            cnt_r    <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            stable_r <= key_state_e'(pressed_s);
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
        end
    end

    assign level = (stable_r == PRESSED);
    // Aligned with the edge at which stable rises, so the pending bit sets together with it.
    assign press = expire_s && (stable_r == RELEASED);

endmodule

// File: rtl/key_event_capture.sv
// Pushbutton front end: per-key debouncers feeding a pending-press vector that
// is drained lowest-index-first through a valid/ready event register.
module key_event_capture
    import key_event_pkg::*;
#(
    parameter int N_KEYS          = N_KEYS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 20,
    parameter int KEY_W           = clog2_min1(N_KEYS)
) (
    input  logic              CLOCK_50,
    input  logic              CPU_RESETn,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic              evt_valid,
    output logic [KEY_W-1:0]  evt_key,
    input  logic              evt_ready,
    output logic              evt_overflow,
    input  logic              ovf_clr
);

    logic [N_KEYS-1:0] level_s;
    logic [N_KEYS-1:0] press_s;
    logic [N_KEYS-1:0] pending_r;
    logic [N_KEYS-1:0] take_s;
    logic [N_KEYS-1:0] pending_nxt_s;
    logic              found_s;
    logic [KEY_W-1:0]  sel_idx_s;
    logic              load_s;
    logic              ovf_set_s;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk   (CLOCK_50),
            .rst_n (CPU_RESETn),
            .key_n (key_n[g]),
            .level (level_s[g]),
            .press (press_s[g])
        );
    end

    // The debouncer's level is already a flop output.
    assign key_level = level_s;

    // Lowest-index pending key; scanning downward lets the lowest index win.
    always_comb begin
        found_s   = 1'b0;
        sel_idx_s = {KEY_W{1'b0}};
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            sel_idx_s = pending_r[i] ? KEY_W'(i) : sel_idx_s;
            found_s   = found_s | pending_r[i];
        end
    end

    // A press on a bit being handed out this cycle is a fresh event, not a loss.
    always_comb begin
        load_s = !evt_valid || evt_ready;
        for (int i = 0; i < N_KEYS; i++) begin
            take_s[i] = load_s && found_s && (sel_idx_s == KEY_W'(i));
        end
        pending_nxt_s = (pending_r & ~take_s) | press_s;
        ovf_set_s     = |(press_s & pending_r & ~take_s);
    end

    // Pending vector, output event register and sticky overflow flag.
    always_ff @(posedge CLOCK_50 or negedge CPU_RESETn) begin
        if (!CPU_RESETn) begin
            pending_r    <= {N_KEYS{1'b0}};
            evt_valid    <= 1'b0;
            evt_key      <= {KEY_W{1'b0}};
            evt_overflow <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            if (load_s && found_s) begin
                evt_valid <= 1'b1;
                evt_key   <= sel_idx_s;
            end else if (load_s) begin
                evt_valid <= 1'b0;
            end else begin
                evt_valid <= evt_valid;
            end
            if (ovf_set_s) begin
                evt_overflow <= 1'b1;
            end else if (ovf_clr) begin
                evt_overflow <= 1'b0;
            end else begin
                evt_overflow <= evt_overflow;
            end
        end
    end

endmodule

// File: tb/tb_key_event_capture.sv
// Scoreboard bench for key_event_capture: a window-based reference model
// predicts levels, events and overflow; a monitor checks the DUT against it.
module tb_key_event_capture;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int KW = 2;

    logic          CLOCK_50 = 1'b0;
    logic          CPU_RESETn;
    logic [N-1:0]  key_n;
    logic          evt_ready;
    logic          ovf_clr;
    logic [N-1:0]  key_level;
    logic          evt_valid;
    logic [KW-1:0] evt_key;
    logic          evt_overflow;

    int n_cmp  = 0;
    int n_fail = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    key_event_capture #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (20),
        .KEY_W           (KW)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .CPU_RESETn   (CPU_RESETn),
        .key_n        (key_n),
        .key_level    (key_level),
        .evt_valid    (evt_valid),
        .evt_key      (evt_key),
        .evt_ready    (evt_ready),
        .evt_overflow (evt_overflow),
        .ovf_clr      (ovf_clr)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model. hist[i][k] is the pressed level sampled k edges ago; the
    // synchronised view at this edge lags two samples, and the debounced level
    // flips once the last D synchronised samples all disagree with it.
    logic [D+1:0] m_hist [N] = '{default: '0};
    logic [N-1:0] m_stable = '0;
    logic [N-1:0] m_pend   = '0;
    logic [N-1:0] m_press;
    logic         m_valid  = 1'b0;
    logic         m_ovf    = 1'b0;
    logic         m_diff;
    int           m_pick;
    int           exp_q[$];

    always @(posedge CLOCK_50 or negedge CPU_RESETn) begin
        if (!CPU_RESETn) begin
            for (int i = 0; i < N; i++) m_hist[i] = '0;
            m_stable = '0;
            m_pend   = '0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            exp_q.delete();
        end else begin
            m_press = '0;
            for (int i = 0; i < N; i++) begin
                m_hist[i] = {m_hist[i][D:0], ~key_n[i]};
                m_diff = 1'b1;
                for (int k = 2; k <= D + 1; k++) begin
                    if (m_hist[i][k] == m_stable[i]) m_diff = 1'b0;
                end
                if (m_diff) begin
                    m_stable[i] = ~m_stable[i];
                    if (m_stable[i]) m_press[i] = 1'b1;
                end
            end
            if (!m_valid || evt_ready) begin
                m_pick = -1;
                for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_pick = i;
                if (m_pick >= 0) begin
                    m_pend[m_pick] = 1'b0;
                    m_valid = 1'b1;
                    exp_q.push_back(m_pick);
                end else begin
                    m_valid = 1'b0;
                end
            end
            if ((m_press & m_pend) != '0) m_ovf = 1'b1;
            else if (ovf_clr)             m_ovf = 1'b0;
            m_pend = m_pend | m_press;
        end
    end

    // Monitor: per-cycle status checks, and a key popped for every transfer.
    int mon_exp;
    always @(negedge CLOCK_50) begin
        check("key_level", 32'(key_level), 32'(m_stable));
        check("evt_valid", 32'(evt_valid), 32'(m_valid));
        check("evt_overflow", 32'(evt_overflow), 32'(m_ovf));
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp  = n_cmp + 1;
                n_fail = n_fail + 1;
                $display("FAIL evt_key at %0t: got %0d expected no event", $time, evt_key);
            end else begin
                mon_exp = exp_q.pop_front();
                check("evt_key", 32'(evt_key), 32'(mon_exp));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    int hold [N];

    initial begin
        CPU_RESETn = 1'b0;
        key_n      = 4'b0000;
        evt_ready  = 1'b1;
        ovf_clr    = 1'b0;
        #25;
        check("rst_key_level", 32'(key_level), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_key", 32'(evt_key), 32'd0);
        check("rst_evt_overflow", 32'(evt_overflow), 32'd0);
        @(negedge CLOCK_50);
        CPU_RESETn = 1'b1;
        tick(20);
        key_n = 4'b1111;
        tick(20);

        // Glitch shorter than the debounce window.
        key_n[2] = 1'b0; tick(3); key_n[2] = 1'b1; tick(10);

        // Held press while the consumer stalls, then a single accept.
        evt_ready = 1'b0;
        key_n[1] = 1'b0; tick(10); key_n[1] = 1'b1; tick(20);
        evt_ready = 1'b1; tick(1); evt_ready = 1'b0; tick(10);

        // Keys 3 and 0 together.
        evt_ready = 1'b1;
        key_n = 4'b0110; tick(12); key_n = 4'b1111; tick(12);

        // Overflow: repeated presses of key 2 while its event is held.
        evt_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            key_n[2] = 1'b0; tick(8); key_n[2] = 1'b1; tick(8);
        end
        check("ovf_set", 32'(evt_overflow), 32'd1);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(1);
        check("ovf_cleared", 32'(evt_overflow), 32'd0);
        // Clear pulse lands on the same edge as a lost press.
        key_n[2] = 1'b0; tick(5); ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(evt_overflow), 32'd1);
        tick(4); key_n[2] = 1'b1;
        evt_ready = 1'b1; tick(12);
        ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0; tick(2);

        // Randomised key activity, stalls and clears.
        for (int i = 0; i < N; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    key_n[i] = 1'($urandom_range(0, 1));
                    hold[i]  = $urandom_range(1, 2 * D + 3);
                end else begin
                    hold[i] = hold[i] - 1;
                end
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            tick(1);
        end
        ovf_clr = 1'b0;
        key_n = 4'b1111; evt_ready = 1'b1; tick(20);

        // Reset in the middle of a held event with keys 1 and 3 pending.
        evt_ready = 1'b0;
        key_n = 4'b1110; tick(10);
        key_n = 4'b0100; tick(10);
        #4;
        CPU_RESETn = 1'b0;
        #1;
        check("mid_rst_key_level", 32'(key_level), 32'd0);
        check("mid_rst_evt_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_evt_key", 32'(evt_key), 32'd0);
        check("mid_rst_evt_overflow", 32'(evt_overflow), 32'd0);
        key_n = 4'b1111;
        tick(3);
        CPU_RESETn = 1'b1;
        tick(20);
        evt_ready = 1'b1;
        tick(20);
        check("no_event_after_reset", 32'(evt_valid), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
